// File: rtl/wb_burst_master_pkg.sv
// Shared types and constants for the Wishbone burst master and its pattern generator.
package wbm_pkg;

  typedef enum logic [1:0] {
    WBM_WAIT_INIT = 2'd0,
    WBM_IDLE      = 2'd1,
    WBM_BURST     = 2'd2,
    WBM_DONE      = 2'd3
  } wbm_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/wb_burst_master_if.sv
// Command handshake plus Wishbone bus bundle between burst master and its slave.
interface wb_burst_master_if #(
  parameter int AW = 26,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [31:0]   cmd_seed;

  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic [DW-1:0]   wb_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_seed, wb_ack_i, wb_dat_i,
    output cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_seed, wb_ack_i, wb_dat_i,
    input  cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
  );
endinterface

// File: rtl/wb_burst_master_pattern_gen.sv
// 32-bit Galois LFSR pattern source; load takes priority over step, a zero seed becomes 1.
module wbm_pattern_gen
  import wbm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       value <= 32'h0;
    else if (load) value <= (seed == 32'h0) ? 32'h1 : seed;
    else if (step) value <= lfsr_next(value);
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone burst master with LFSR write pattern and read-back checking.
// Optional per-beat ack watchdog is built when WBM_TIMEOUT_EN is defined.
module wb_burst_master
  import wbm_pkg::*;
#(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                sdr_init_done,
  wb_burst_master_if.master   bus,
  output logic                busy_o,
  output logic                done_o,
  output logic [15:0]         err_cnt_o,
  output logic                timeout_o
);

  localparam logic [1:0]    ST_WAIT  = 2'(WBM_WAIT_INIT);
  localparam logic [1:0]    ST_IDLE  = 2'(WBM_IDLE);
  localparam logic [1:0]    ST_BURST = 2'(WBM_BURST);
  localparam logic [1:0]    ST_DONE  = 2'(WBM_DONE);
  localparam logic [AW-1:0] STEP     = AW'(DW / 8);

  if (DW < 8 || DW > 32 || (DW % 8) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("wb_burst_master: illegal DW or TIMEOUT");
  end

  logic [1:0]    state;
  logic          cyc;
  logic          we;
  logic [AW-1:0] addr;
  logic [2:0]    cti;
  logic [7:0]    remain;
  logic [31:0]   pattern;
  logic          hs;
  logic          beat_ack;
  logic          tmo_hit;

  assign bus.cmd_ready = (state == ST_IDLE);
  assign hs            = bus.cmd_valid & bus.cmd_ready;
  assign beat_ack      = (state == ST_BURST) & bus.wb_ack_i;

  wbm_pattern_gen u_pat (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .load  (hs),
    .step  (beat_ack),
    .seed  (bus.cmd_seed),
    .value (pattern)
  );

  // remain counts beats still to be acked after the current one.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= ST_WAIT;
      cyc    <= 1'b0;
      we     <= 1'b0;
      addr   <= '0;
      cti    <= CTI_CLASSIC;
      remain <= 8'd0;
    end else begin
      case (state)
        ST_WAIT: if (sdr_init_done) state <= ST_IDLE;
        ST_IDLE: begin
          if (hs) begin
            state  <= ST_BURST;
            cyc    <= 1'b1;
            we     <= bus.cmd_we;
            addr   <= bus.cmd_addr;
            remain <= bus.cmd_len;
            cti    <= (bus.cmd_len == 8'd0) ? CTI_CLASSIC : CTI_INCR;
          end else if (!sdr_init_done) begin
            state <= ST_WAIT;
          end
        end
        ST_BURST: begin
          if (beat_ack) begin
            addr <= addr + STEP;
            if (remain == 8'd0) begin
              state <= ST_DONE;
              cyc   <= 1'b0;
            end else begin
              remain <= remain - 8'd1;
              cti    <= (remain == 8'd1) ? CTI_END : CTI_INCR;
            end
          end else if (tmo_hit) begin
            state <= ST_DONE;
            cyc   <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      err_cnt_o <= 16'h0;
    else if (beat_ack && !we && bus.wb_dat_i != pattern[DW-1:0] && err_cnt_o != 16'hFFFF)
      err_cnt_o <= err_cnt_o + 16'h1;
  end

`ifdef WBM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          tmo_q;

  // Counts idle BURST cycles since the last ack; holds once the limit is reached.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tcnt  <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (hs || beat_ack)                                   tcnt <= '0;
      else if (state == ST_BURST && tcnt != TW'(TIMEOUT))   tcnt <= tcnt + 1'b1;
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end

  assign tmo_hit   = (state == ST_BURST) && !bus.wb_ack_i && (tcnt == TW'(TIMEOUT));
  assign timeout_o = tmo_q;
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign bus.wb_cyc_o  = cyc;
  assign bus.wb_stb_o  = cyc;
  assign bus.wb_we_o   = we;
  assign bus.wb_addr_o = addr;
  assign bus.wb_dat_o  = pattern[DW-1:0];
  assign bus.wb_sel_o  = {(DW/8){cyc}};
  assign bus.wb_cti_o  = cti;

  assign busy_o = (state == ST_BURST) || (state == ST_DONE);
  assign done_o = (state == ST_DONE);

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench: random-ack memory slave plus a spec-level burst/LFSR model.
module tb_wb_burst_master;
  localparam int AW = 26;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    cti;
    logic [31:0]   dat;
    logic          we;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_done = 1'b0;
  logic        busy, done, tmo;
  logic [15:0] err;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ack_pct = 70;
  int          done_cnt = 0;
  logic [15:0] exp_err = 16'h0;
  beat_t       log_q[$];
  logic [31:0] mem [logic [AW-1:0]];

  wb_burst_master_if #(.AW(AW), .DW(DW)) bus ();

  wb_burst_master #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .sdr_init_done (init_done),
    .bus           (bus),
    .busy_o        (busy),
    .done_o        (done),
    .err_cnt_o     (err),
    .timeout_o     (tmo)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : ({6'd0, a} ^ 32'hA5A5_0000);
  endfunction

  function automatic logic [31:0] model_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory slave: decides ack on the falling edge so it is stable at the next rising edge.
  initial begin
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (!rst && bus.wb_cyc_o && bus.wb_stb_o && ($urandom_range(0, 99) < ack_pct)) begin
        beat_t b;
        b.addr = bus.wb_addr_o; b.cti = bus.wb_cti_o; b.dat = bus.wb_dat_o; b.we = bus.wb_we_o;
        log_q.push_back(b);
        bus.wb_ack_i = 1'b1;
        if (bus.wb_we_o) mem[bus.wb_addr_o] = bus.wb_dat_o;
        else             bus.wb_dat_i = mem_rd(bus.wb_addr_o);
      end else begin
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = $urandom;
      end
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [7:0] len,
                       input logic [31:0] seed, output bit ok);
    int waited = 0;
    while (!bus.cmd_ready && waited < 50) begin tick(); waited++; end
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL handshake: cmd_ready=%b want 1", bus.cmd_ready);
      ok = 0; return;
    end
    log_q.delete();
    bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_addr = addr;
    bus.cmd_len = len; bus.cmd_seed = seed;
    tick();
    bus.cmd_valid = 1'b0;
    ok = 1;
  endtask

  task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [31:0] seed, input string nm);
    bit ok;
    int waited = 0, bad = 0, d0, L;
    logic [31:0] pat;
    logic [AW-1:0] a;
    logic [2:0] ecti;
    L = int'(len);
    d0 = done_cnt;
    issue(we, addr, len, seed, ok);
    if (!ok) return;
    while (!done && waited < 5000) begin tick(); waited++; end
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL %s done: never seen", nm); return; end
    n_cmp++;
    if ({bus.wb_cyc_o, bus.wb_stb_o} !== 2'b00) begin
      n_bad++; $display("FAIL %s bus_at_done: cyc/stb=%b want 00", nm, {bus.wb_cyc_o, bus.wb_stb_o});
    end
    tick();
    n_cmp++;
    if ({bus.cmd_ready, done} !== 2'b10) begin
      n_bad++; $display("FAIL %s ready_after: ready/done=%b want 10", nm, {bus.cmd_ready, done});
    end
    n_cmp++;
    if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL %s done_pulses: got %0d want 1", nm, done_cnt - d0); end
    pat = (seed == 32'h0) ? 32'h1 : seed;
    a = addr;
    for (int i = 0; i <= L; i++) begin
      ecti = (L == 0) ? 3'b000 : ((i == L) ? 3'b111 : 3'b010);
      if (i < log_q.size()) begin
        if (log_q[i].addr !== a || log_q[i].cti !== ecti || log_q[i].we !== we ||
            (we && log_q[i].dat !== pat)) bad++;
      end
      if (!we && mem_rd(a) !== pat && exp_err != 16'hFFFF) exp_err = exp_err + 16'h1;
      a = a + AW'(4);
      pat = model_step(pat);
    end
    n_cmp++;
    if (log_q.size() != L + 1) begin
      n_bad++; $display("FAIL %s beat_count: got %0d want %0d", nm, log_q.size(), L + 1);
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL %s beats: %0d wrong beats want 0", nm, bad); end
    n_cmp++;
    if (err !== exp_err) begin n_bad++; $display("FAIL %s err_cnt: got %0d want %0d", nm, err, exp_err); end
  endtask

  task automatic test_reset();
    bit saw_ready = 0, saw_cyc = 0;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_seed = '0;
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_addr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_cti_o} !== '0) begin
      n_bad++; $display("FAIL reset_wb: cyc=%b addr=%h dat=%h sel=%b cti=%b want all 0",
                        bus.wb_cyc_o, bus.wb_addr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_cti_o);
    end
    n_cmp++;
    if ({bus.cmd_ready, busy, done, err, tmo} !== '0) begin
      n_bad++; $display("FAIL reset_status: ready=%b busy=%b done=%b err=%0d tmo=%b want 0",
                        bus.cmd_ready, busy, done, err, tmo);
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.cmd_ready) saw_ready = 1;
      if (bus.wb_cyc_o || bus.wb_stb_o) saw_cyc = 1;
    end
    n_cmp++;
    if (saw_ready) begin n_bad++; $display("FAIL wait_init_ready: saw 1 want 0"); end
    n_cmp++;
    if (saw_cyc) begin n_bad++; $display("FAIL wait_init_bus: saw cyc want none"); end
    init_done = 1'b1;
    tick();
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL init_ready: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_write_read();
    run_cmd(1'b1, 26'h100, 8'd7, 32'h1234, "wr8");
    run_cmd(1'b0, 26'h100, 8'd7, 32'h1234, "rd8");
  endtask

  task automatic test_bad_seed();
    logic [15:0] e0 = err;
    run_cmd(1'b0, 26'h100, 8'd7, 32'h1235, "rd_bad");
    n_cmp++;
    if (err - e0 !== 16'd8) begin n_bad++; $display("FAIL bad_seed_delta: got %0d want 8", err - e0); end
  endtask

  task automatic test_wrap();
    run_cmd(1'b1, 26'h3FFFFFC, 8'd0, 32'hCAFE, "single");
    run_cmd(1'b1, 26'h3FFFFFC, 8'd1, 32'hBEEF, "wrap");
    run_cmd(1'b0, 26'h3FFFFFC, 8'd1, 32'hBEEF, "wrap_rd");
  endtask

  task automatic test_random();
    ack_pct = 60;
    for (int i = 0; i < 10; i++) begin
      logic [AW-1:0] a = 26'h1000 + AW'({$urandom_range(0, 63), 2'b00});
      logic [7:0] l = 8'($urandom_range(0, 31));
      logic [31:0] s = (i == 3) ? 32'h0 : $urandom;
      logic w = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      run_cmd(w, a, l, s, "rand");
    end
    ack_pct = 70;
  endtask

  task automatic test_init_drop();
    init_done = 1'b0;
    tick();
    n_cmp++;
    if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL init_drop: ready=%b want 0", bus.cmd_ready); end
    init_done = 1'b1;
    tick();
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL init_return: ready=%b want 1", bus.cmd_ready); end
  endtask

  task automatic test_reset_midburst();
    bit ok;
    int waited = 0, d0;
    ack_pct = 100;
    d0 = done_cnt;
    issue(1'b1, 26'h2000, 8'd15, 32'h55AA, ok);
    if (!ok) return;
    while (log_q.size() < 3 && waited < 100) begin tick(); waited++; end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, busy} !== 3'b000) begin
      n_bad++; $display("FAIL rst_mid_bus: cyc/stb/busy=%b want 000", {bus.wb_cyc_o, bus.wb_stb_o, busy});
    end
    tick(); tick();
    rst = 1'b0;
    exp_err = 16'h0;
    n_cmp++;
    if ({bus.cmd_ready, busy, err} !== '0) begin
      n_bad++; $display("FAIL rst_mid_state: ready=%b busy=%b err=%0d want 0", bus.cmd_ready, busy, err);
    end
    tick(); tick();
    n_cmp++;
    if (done_cnt != d0) begin n_bad++; $display("FAIL rst_mid_done: got %0d pulses want 0", done_cnt - d0); end
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_idle: ready=%b want 1", bus.cmd_ready); end
    ack_pct = 70;
    run_cmd(1'b1, 26'h2000, 8'd3, 32'h77, "post_rst");
  endtask

`ifdef WBM_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int hi = 0, d0;
    ack_pct = 0;
    d0 = done_cnt;
    issue(1'b1, 26'h3000, 8'd3, 32'h99, ok);
    if (!ok) return;
    while (bus.wb_cyc_o && hi < 100) begin tick(); hi++; end
    n_cmp++;
    if (hi != 17) begin n_bad++; $display("FAIL tmo_cycles: cyc high %0d want 17", hi); end
    n_cmp++;
    if ({tmo, done} !== 2'b11) begin n_bad++; $display("FAIL tmo_flag: tmo/done=%b want 11", {tmo, done}); end
    tick(); tick();
    n_cmp++;
    if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL tmo_done: got %0d pulses want 1", done_cnt - d0); end
    ack_pct = 70;
  endtask
`endif

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_bad_seed();
    test_wrap();
    test_random();
    test_init_drop();
    test_reset_midburst();
`ifdef WBM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Wishbone burst master that drives the system-side port of `sdrc_top` (the `wb_*` signals on the `sys_clk` domain). It accepts one burst command at a time, generates a self-checking LFSR data pattern for writes, and compares read data against the same pattern. It provides bench and bring-up traffic for the SDRAM controller in 8/16/32-bit SDRAM builds; the controller hides the SDRAM width behind a 32-bit Wishbone port.

## Interface
- `AW`, 26: Wishbone byte-address width.
- `DW`, 32: Wishbone data width; legal range 8..32, multiple of 8.
- `TIMEOUT`, 1024: cycles allowed per beat for `wb_ack_i` (used only with `WBM_TIMEOUT_EN`).

Ports:
- `wb_clk_i`  in  1  system clock.
- `wb_rst_i`  in  1  asynchronous reset, active-high.
- `sdr_init_done`  in  1  controller initialisation complete.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_we`  in  1  1 = write burst, 0 = read-and-check burst.
- `cmd_addr`  in  AW  start byte address, DW/8-aligned.
- `cmd_len`  in  8  beats minus 1 (1..256 beats).
- `cmd_seed`  in  32  LFSR seed; 0 is replaced by 32'h1.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone cycle, strobe and write enable.
- `wb_addr_o`  out  AW  Wishbone address.
- `wb_dat_o`  out  DW  write data.
- `wb_sel_o`  out  DW/8  byte selects; all ones when active.
- `wb_cti_o`  out  3  cycle type identifier.
- `wb_ack_i`  in  1  Wishbone acknowledge.
- `wb_dat_i`  in  DW  read data.
- `busy_o`  out  1  high in all states except IDLE and WAIT_INIT.
- `done_o`  out  1  one-cycle pulse when a burst ends.
- `err_cnt_o`  out  16  read-mismatch count; saturates at 16'hFFFF.
- `timeout_o`  out  1  sticky timeout flag.

## Operation
- FSM states: WAIT_INIT, IDLE, BURST, DONE.
  - Reset enters WAIT_INIT.
  - WAIT_INIT → IDLE when `sdr_init_done` is 1.
  - IDLE → BURST on the `cmd_valid & cmd_ready` handshake.
  - BURST → DONE on the last ack, or on a timeout.
  - DONE → IDLE after one cycle.
- `cmd_ready` is 1 only in IDLE. Command fields are captured at the handshake.
- LFSR: 32-bit Galois, polynomial 0x80200003, shift right, loaded with the seed at the handshake.
  - Beat data is `lfsr[DW-1:0]`.
  - The LFSR advances once per ack.
- Write burst: `wb_dat_o` carries the beat pattern.
- Read burst: `wb_dat_i` is compared against the beat pattern on each ack. A mismatch increments `err_cnt_o` (saturating).
- Address rule: `wb_addr_o` advances by DW/8 on each ack and wraps modulo 2^AW.
- CTI rule:
  - Single-beat burst (`cmd_len`=0): 3'b000.
  - Multi-beat burst: 3'b010 on every beat except the last, 3'b111 on the last.
- `err_cnt_o` and `timeout_o` are cleared only by reset.
- Reset values:
  - All Wishbone outputs are 0 (`wb_sel_o`=0).
  - `cmd_ready`, `busy_o`, `done_o`, `err_cnt_o` and `timeout_o` are 0.
- Reset mid-burst: `wb_cyc_o`/`wb_stb_o` drop asynchronously and the FSM returns to WAIT_INIT. No done pulse is produced.
- If `sdr_init_done` falls while in IDLE, the FSM returns to WAIT_INIT. A burst in progress is unaffected.

## Timing
- A handshake in cycle N gives registered `wb_cyc_o`/`wb_stb_o`/address/data/CTI in cycle N+1.
- `wb_stb_o` stays high for the whole burst; the master inserts no wait states.
- An ack in cycle k gives the next beat's address, data and CTI in cycle k+1.
- Last ack in cycle k:
  - `wb_cyc_o`/`wb_stb_o` are low and `done_o` is high in k+1 (DONE).
  - `cmd_ready` is high in k+2.
- `err_cnt_o` reflects a mismatched ack one cycle after that ack.
- Back-to-back commands are therefore spaced at least 2 idle Wishbone cycles apart.

## Configuration
- `WBM_TIMEOUT_EN` defined:
  - A per-beat counter restarts on every ack and at burst start.
  - Reaching `TIMEOUT` without an ack drops `wb_cyc_o`/`wb_stb_o` the next cycle, sets `timeout_o` and enters DONE (`done_o` pulses).
- `WBM_TIMEOUT_EN` not defined: no counter is built, `timeout_o` is tied to 0, and the master waits indefinitely for ack.

## Structure
- Package `wbm_pkg`: FSM state enum, CTI constants (`CTI_CLASSIC`=3'b000, `CTI_INCR`=3'b010, `CTI_END`=3'b111), LFSR polynomial constant.
- Sub-module `wbm_pattern_gen`: the LFSR, with load (seed) and step inputs and a 32-bit value output.
  - Each burst instantiates one.
  - The same module is reused by bench scoreboards.

## Test plan
- Reset released and `sdr_init_done` held at 0 for 100 cycles → `cmd_ready` stays 0 and there is no Wishbone activity. `sdr_init_done` rises → `cmd_ready`=1 the next cycle.
- Write with len=7, addr=0x100, seed=0x1234, then read with the same fields, against `sdrc_top` → 8 beats each, CTI 010×7 then 111, addresses 0x100..0x11C, `err_cnt_o`=0, two `done_o` pulses.
- Read with seed=0x1235 over the region just written → `err_cnt_o`=8.
- Single beat at addr=0x3FFFFFC (len=0) → CTI=000, one beat. Then len=1 at the same address → second beat at address 0x0 (wrap).
- Assert `wb_rst_i` during beat 3 of a 16-beat write → `wb_cyc_o` falls in the same cycle, no `done_o` pulse, FSM back in WAIT_INIT.
- With `WBM_TIMEOUT_EN` and `TIMEOUT`=16, a slave that never acks → `wb_cyc_o` drops after 17 cycles, `timeout_o`=1, one `done_o` pulse.
